// File: rtl/sample_readout_if.sv
// Bus bundle for the readout block: sample-memory read port plus byte stream to the UART TX path.
// The master side is the readout engine, the slave side is the memory manager together with the transmitter.
interface sample_readout_if #(
    parameter int WIDTH = 32
);
    logic             mem_read;
    logic [WIDTH-1:0] mem_data;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output mem_read,
        output tx_data,
        output tx_valid,
        input  mem_data,
        input  tx_ready
    );

    modport slave (
        input  mem_read,
        input  tx_data,
        input  tx_valid,
        output mem_data,
        output tx_ready
    );
endinterface

// File: rtl/sample_readout.sv
// Pulls captured samples out of sample RAM one strobe at a time.
// Each sample is split into bytes, disabled channel groups are dropped, and the remaining bytes are streamed to the UART.
//
// state | meaning
// IDLE  | waiting for start_i; busy_o low
// FETCH | mem read strobe asserted for this single cycle
// WAIT  | counting down the memory latency; captures the sample on terminal count
// SEND  | walking the bytes LSB first; valid held until ready, masked bytes skipped in one cycle
// NEXT  | decrement the remaining count; fetch again or finish
// FIN   | done_o pulse; start_i ignored
module sample_readout #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   read_cnt_i,
    input  logic [WIDTH/8-1:0] grp_dis_i,
    sample_readout_if.master   bus,
    output logic               busy_o,
    output logic               done_o
);
    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [2:0]       LAT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        NEXT,
        FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [NB-1:0]    mask;
    logic [WIDTH-1:0] sample;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [2:0]       lat_cnt;

    assign nxt_idx = byte_idx + IDX_W'(1);

    function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] s, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NB; k++) begin
            if (idx == IDX_W'(k)) b = s[8*k +: 8];
        end
        return b;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            remaining    <= '0;
            mask         <= '0;
            sample       <= '0;
            byte_idx     <= '0;
            lat_cnt      <= '0;
            bus.mem_read <= 1'b0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            bus.mem_read <= 1'b0;
            done_o       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        remaining <= read_cnt_i;
                        mask      <= grp_dis_i;
                        busy_o    <= 1'b1;
                        if (read_cnt_i == '0) begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            bus.mem_read <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        // Present byte 0 straight away so an enabled first byte costs no extra cycle.
                        sample       <= bus.mem_data;
                        byte_idx     <= '0;
                        bus.tx_data  <= bus.mem_data[7:0];
                        bus.tx_valid <= ~mask[0];
                        state        <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                SEND: begin
                    // With valid low here the current byte is a masked one being skipped.
                    if (!bus.tx_valid || bus.tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            bus.tx_valid <= 1'b0;
                            state        <= NEXT;
                        end else begin
                            byte_idx     <= nxt_idx;
                            bus.tx_data  <= byte_sel(sample, nxt_idx);
                            bus.tx_valid <= ~mask[nxt_idx];
                        end
                    end
                end
                NEXT: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state  <= FIN;
                        done_o <= 1'b1;
                    end else begin
                        state        <= FETCH;
                        bus.mem_read <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
